// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_pkg
// Brief  : Shared FSM state type, R/W bit encoding and frame-width helper
//          for the SPI register bank.
// Rev    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic c_RW_WRITE = 1'b1;
    localparam logic c_RW_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module : spi_reg_bank_if
// Brief  : SPI pin bundle (mode 0) between a controller and the register bank.
// Rev    : 1.0 - initial release
// ============================================================================
interface spi_reg_bank_if;
    logic sclk;
    logic cs_n;
    logic copi;
    logic cipo;

    modport master (output sclk, output cs_n, output copi, input cipo);
    modport slave  (input sclk, input cs_n, input copi, output cipo);
endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : spi_sync_edge
// Brief  : Multi-flop synchroniser for an asynchronous pin with rise/fall
//          detection on the synchronised samples.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : spi_reg_bank
// Brief  : SPI-slave register bank, all pins oversampled by clk; writes
//          update held registers, reads return data MSB first on cipo.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int                c_FRAME_W  = frame_w(ADDR_W, DATA_W);
    localparam int                c_HDR_W    = 1 + ADDR_W;
    localparam int                c_CNT_W    = $clog2(c_FRAME_W + 1);
    localparam logic [ADDR_W:0]   c_NREGS_EXT = (ADDR_W+1)'(NUM_REGS);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_copi, w_copi_rise, w_copi_fall;
    logic w_unused_edges;

    // cs_n resets low so a reset inside an active frame cannot fake a falling edge
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(spi.sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst(rst), .i_async(spi.cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .i_async(spi.copi),
        .o_level(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );
    assign w_unused_edges = w_sclk_level | w_copi_rise | w_copi_fall;

    state_t                      r_state;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_FRAME_W-1:0]        r_sh;
    logic [DATA_W-1:0]           r_rd_sh;
    logic                        r_rd_en;
    logic                        r_rd_phase;
    logic                        r_commit;
    logic                        r_cipo;
    logic [NUM_REGS*DATA_W-1:0]  r_regs;
    logic                        r_wr_strobe;
    logic [ADDR_W-1:0]           r_wr_addr;
    logic                        r_frame_err;

    logic [c_FRAME_W-1:0] w_sh_next;
    logic [ADDR_W-1:0]    w_hdr_addr;
    logic [ADDR_W-1:0]    w_frm_addr;
    logic [DATA_W-1:0]    w_frm_data;
    logic                 w_frm_rw;
    logic                 w_frm_in_range;
    logic [DATA_W-1:0]    w_rd_word;

    assign w_sh_next      = {r_sh[c_FRAME_W-2:0], w_copi};
    assign w_hdr_addr     = w_sh_next[ADDR_W-1:0];
    assign w_frm_rw       = r_sh[c_FRAME_W-1];
    assign w_frm_addr     = r_sh[c_FRAME_W-2 -: ADDR_W];
    assign w_frm_data     = r_sh[DATA_W-1:0];
    assign w_frm_in_range = ({1'b0, w_frm_addr} < c_NREGS_EXT);

    // Out-of-range addresses match no entry and read back as zero
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_hdr_addr == ADDR_W'(k)) begin
                w_rd_word = r_regs[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_rd_sh     <= '0;
            r_rd_en     <= 1'b0;
            r_rd_phase  <= 1'b0;
            r_commit    <= 1'b0;
            r_cipo      <= 1'b0;
            r_regs      <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_cipo      <= (r_state == SHIFT) && r_rd_en && r_rd_phase && r_rd_sh[DATA_W-1];
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state    <= SHIFT;
                        r_cnt      <= '0;
                        r_sh       <= '0;
                        r_rd_en    <= 1'b0;
                        r_rd_phase <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_sh  <= w_sh_next;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(c_HDR_W - 1)) begin
                            r_rd_sh <= w_rd_word;
                            r_rd_en <= (w_sh_next[ADDR_W] == c_RW_READ);
                        end
                    end
                    // First data-phase fall exposes the MSB; later falls advance
                    if (w_sclk_fall && (r_cnt >= c_CNT_W'(c_HDR_W))) begin
                        if (r_rd_phase) begin
                            r_rd_sh <= {r_rd_sh[DATA_W-2:0], 1'b0};
                        end
                        r_rd_phase <= 1'b1;
                    end
                    if (w_sclk_rise && (r_cnt == c_CNT_W'(c_FRAME_W - 1))) begin
                        r_state  <= DONE;
                        r_commit <= 1'b1;
                    end else if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end
                end
                DONE: begin
                    r_commit <= 1'b0;
                    if (r_commit) begin
                        if (!w_frm_in_range) begin
                            r_frame_err <= 1'b1;
                        end else if (w_frm_rw == c_RW_WRITE) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (w_frm_addr == ADDR_W'(k)) begin
                                    r_regs[k*DATA_W +: DATA_W] <= w_frm_data;
                                end
                            end
                            r_wr_strobe <= 1'b1;
                            r_wr_addr   <= w_frm_addr;
                        end
                    end
                    if (w_cs_level) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi.cipo  = r_cipo;
    assign regs      = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_reg_bank
// Brief  : Self-checking bench for spi_reg_bank in two configurations sharing
//          sclk/copi, each with its own chip select.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

    localparam int HP   = 6;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    logic sclk_d, copi_d, cs_a, cs_b;
    always #5 clk = ~clk;

    spi_reg_bank_if spi_a ();
    spi_reg_bank_if spi_b ();
    assign spi_a.sclk = sclk_d;
    assign spi_a.copi = copi_d;
    assign spi_a.cs_n = cs_a;
    assign spi_b.sclk = sclk_d;
    assign spi_b.copi = copi_d;
    assign spi_b.cs_n = cs_b;

    logic [39:0]  a_regs;
    logic         a_wr_strobe, a_frame_err;
    logic [6:0]   a_wr_addr;
    logic [255:0] b_regs;
    logic         b_wr_strobe, b_frame_err;
    logic [3:0]   b_wr_addr;

    spi_reg_bank #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .SYNC_STAGES(SYNC)) u_dut_a (
        .clk(clk), .rst(rst), .spi(spi_a), .regs(a_regs),
        .wr_strobe(a_wr_strobe), .wr_addr(a_wr_addr), .frame_err(a_frame_err)
    );
    spi_reg_bank #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .SYNC_STAGES(SYNC)) u_dut_b (
        .clk(clk), .rst(rst), .spi(spi_b), .regs(b_regs),
        .wr_strobe(b_wr_strobe), .wr_addr(b_wr_addr), .frame_err(b_frame_err)
    );

    int n_checks = 0;
    int n_err    = 0;
    int strobe_cnt[2] = '{0, 0};
    int ferr_cnt[2]   = '{0, 0};

    int unsigned m_regs[2][16];
    int          exp_str[2];
    int          exp_ferr[2];
    int unsigned exp_wa[2];

    always @(posedge clk) begin
        if (a_wr_strobe) strobe_cnt[0] <= strobe_cnt[0] + 1;
        if (b_wr_strobe) strobe_cnt[1] <= strobe_cnt[1] + 1;
        if (a_frame_err) ferr_cnt[0] <= ferr_cnt[0] + 1;
        if (b_frame_err) ferr_cnt[1] <= ferr_cnt[1] + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic int nr(input int s); return (s == 0) ? 5 : 16; endfunction
    function automatic int aw(input int s); return (s == 0) ? 7 : 4;  endfunction
    function automatic int dw(input int s); return (s == 0) ? 8 : 16; endfunction

    function automatic int unsigned dut_reg(input int s, input int k);
        if (s == 0) return 32'(a_regs[k*8 +: 8]);
        return 32'(b_regs[k*16 +: 16]);
    endfunction
    function automatic logic cipo_of(input int s);
        return (s == 0) ? spi_a.cipo : spi_b.cipo;
    endfunction
    function automatic int unsigned wr_addr_of(input int s);
        return (s == 0) ? 32'(a_wr_addr) : 32'(b_wr_addr);
    endfunction

    function automatic logic [31:0] mk(input int s, input int unsigned rw,
                                       input int unsigned addr, input int unsigned data);
        int fw;
        fw = 1 + aw(s) + dw(s);
        return (rw << (fw - 1)) | (addr << dw(s)) | (data & ((32'd1 << dw(s)) - 1));
    endfunction

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cs(input int s, input logic v);
        if (s == 0) cs_a = v;
        else        cs_b = v;
    endtask

    task automatic send_bit(input int s, input logic b, input bit cs_up, output logic c);
        copi_d = b;
        wait_clks(HP);
        c = cipo_of(s);
        sclk_d = 1'b1;
        if (cs_up) set_cs(s, 1'b1);
        wait_clks(HP);
        sclk_d = 1'b0;
    endtask

    task automatic check_regs(input int s, input string tag);
        for (int k = 0; k < nr(s); k++)
            check($sformatf("%s cfg%0d reg%0d", tag, s, k), dut_reg(s, k), m_regs[s][k]);
    endtask

    task automatic check_counts(input int s, input string tag);
        for (int t = 0; t < 2; t++) begin
            check($sformatf("%s cfg%0d strobes", tag, t), strobe_cnt[t], exp_str[t]);
            check($sformatf("%s cfg%0d frame_errs", tag, t), ferr_cnt[t], exp_ferr[t]);
        end
        check($sformatf("%s cfg%0d wr_addr", tag, s), wr_addr_of(s), exp_wa[s]);
    endtask

    task automatic run_frame(input int s, input logic [31:0] word, input int nbits,
                             input int extra, input bit cs_at_last, input string tag);
        int fw, hdr;
        int unsigned rw, addr, data, exp_rd;
        logic [31:0] rd;
        logic hdr_nz, c;
        fw     = 1 + aw(s) + dw(s);
        hdr    = 1 + aw(s);
        rw     = (word >> (fw - 1)) & 32'd1;
        addr   = (word >> dw(s)) & ((32'd1 << aw(s)) - 1);
        data   = word & ((32'd1 << dw(s)) - 1);
        exp_rd = (rw == 0 && addr < 32'(nr(s))) ? m_regs[s][addr] : 0;
        rd     = '0;
        hdr_nz = 1'b0;
        set_cs(s, 1'b0);
        wait_clks(HP);
        for (int i = 0; i < nbits; i++) begin
            send_bit(s, word[fw-1-i], cs_at_last && (i == nbits - 1), c);
            if (i < hdr) hdr_nz = hdr_nz | c;
            else         rd = {rd[30:0], c};
        end
        for (int i = 0; i < extra; i++) send_bit(s, 1'($urandom), 1'b0, c);
        wait_clks(HP);
        set_cs(s, 1'b1);
        wait_clks(3 * HP);
        if (nbits < fw)                  exp_ferr[s]++;
        else if (addr >= 32'(nr(s)))     exp_ferr[s]++;
        else if (rw == 1) begin
            m_regs[s][addr] = data;
            exp_str[s]++;
            exp_wa[s] = addr;
        end
        check_counts(s, tag);
        if (nbits >= fw) begin
            check($sformatf("%s cfg%0d cipo data", tag, s), rd, exp_rd);
            check($sformatf("%s cfg%0d cipo header", tag, s), 32'(hdr_nz), 0);
        end
        check_regs(s, tag);
    endtask

    initial begin
        logic [31:0]  w;
        logic         c;
        int unsigned  mask, amax;
        int           fw, hdr;
        rst = 1'b1; sclk_d = 1'b0; copi_d = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) m_regs[s][k] = 0;
            exp_str[s] = 0; exp_ferr[s] = 0; exp_wa[s] = 0;
        end
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2 * HP);

        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset cfg%0d cipo", s), 32'(cipo_of(s)), 0);
            check_counts(s, "reset");
            check_regs(s, "reset");
        end

        for (int s = 0; s < 2; s++) begin
            fw   = 1 + aw(s) + dw(s);
            hdr  = 1 + aw(s);
            mask = (32'd1 << dw(s)) - 1;
            run_frame(s, mk(s, 1, 1, 32'hA5A5), fw, 0, 0, "wr_addr1");
            run_frame(s, mk(s, 1, 3, 32'h5A5A), fw, 0, 0, "wr_addr3");
            run_frame(s, mk(s, 1, 2, 32'h3C3C), fw, 0, 0, "wr_addr2");
            run_frame(s, mk(s, 0, 2, $urandom), fw, 0, 0, "rd_addr2");
            if (nr(s) < (1 << aw(s))) begin
                run_frame(s, mk(s, 1, nr(s), mask), fw, 0, 0, "wr_oor");
                run_frame(s, mk(s, 0, nr(s), 0), fw, 0, 0, "rd_oor");
            end
            run_frame(s, mk(s, 1, 0, 32'h1234), 10, 0, 0, "abort");
            run_frame(s, mk(s, 1, 0, 32'h0F0F), fw, 0, 0, "wr_after_abort");
            run_frame(s, mk(s, 1, 4, 32'hC3E1), fw, 4, 0, "extra_sclk");
            run_frame(s, mk(s, 1, 1, 32'h6D29), fw, 0, 1, "cs_with_last");
            run_frame(s, mk(s, 0, 1, 0), fw, 0, 0, "rd_addr1");

            amax = (nr(s) < (1 << aw(s))) ? 32'(nr(s)) : 32'(nr(s) - 1);
            for (int r = 0; r < 20; r++)
                run_frame(s, mk(s, $urandom_range(0, 1), $urandom_range(0, amax), $urandom),
                          fw, 0, 0, "random");

            // Reset while a read of an all-ones register is shifting out
            run_frame(s, mk(s, 1, 2, mask), fw, 0, 0, "pre_rst");
            w = mk(s, 0, 2, 0);
            set_cs(s, 1'b0);
            wait_clks(HP);
            for (int i = 0; i < hdr + 2; i++) send_bit(s, w[fw-1-i], 1'b0, c);
            wait_clks(HP);
            check($sformatf("pre_rst cfg%0d cipo", s), 32'(cipo_of(s)), 1);
            rst = 1'b1;
            wait_clks(1);
            for (int t = 0; t < 2; t++) begin
                for (int k = 0; k < 16; k++) m_regs[t][k] = 0;
                exp_wa[t] = 0;
            end
            check($sformatf("mid_rst cfg%0d cipo", s), 32'(cipo_of(s)), 0);
            check_regs(0, "mid_rst");
            check_regs(1, "mid_rst");
            rst = 1'b0;
            for (int i = hdr + 2; i < fw; i++) send_bit(s, w[fw-1-i], 1'b0, c);
            wait_clks(HP);
            set_cs(s, 1'b1);
            wait_clks(3 * HP);
            check_counts(s, "rst_tail");
            check_regs(s, "rst_tail");
            run_frame(s, mk(s, 1, 3, $urandom), fw, 0, 0, "post_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
